// File: rtl/inst_decode_stage.sv
// IF/ID stage: decodes RV32I fields, immediates and class into a registered bundle,
// with a one-entry skid buffer so that an execute stall never drops a fetched instruction.
module inst_decode_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inst_ready,
  input  logic [XLEN-1:0] inst_code,
  input  logic [XLEN-1:0] cur_inst_addr,
  input  logic [XLEN-1:0] next_inst_addr,
  input  logic            control_hazard,
  input  logic            flush,
  input  logic            ex_ready,
  output logic            next_en,
  output logic            dec_valid,
  output logic [XLEN-1:0] dec_pc,
  output logic [XLEN-1:0] dec_next_pc,
  output logic [XLEN-1:0] dec_inst,
  output logic [4:0]      dec_rd,
  output logic [4:0]      dec_rs1,
  output logic [4:0]      dec_rs2,
  output logic [2:0]      dec_funct3,
  output logic [6:0]      dec_funct7,
  output logic [XLEN-1:0] dec_imm,
  output logic [10:0]     dec_class,
  output logic            dec_is_mret,
  output logic            dec_pred_nt,
  output logic            dec_illegal
);

  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_ALUI   = 7'b0010011,
    OP_ALUR   = 7'b0110011,
    OP_SYSTEM = 7'b1110011,
    OP_FENCE  = 7'b0001111
  } opcode_e;

  // Bit positions inside the one-hot dec_class vector.
  typedef enum int unsigned {
    C_LUI, C_AUIPC, C_JAL, C_JALR, C_BRANCH, C_LOAD,
    C_STORE, C_ALUI, C_ALUR, C_SYSTEM, C_FENCE
  } class_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] npc;
    logic [XLEN-1:0] inst;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [XLEN-1:0] imm;
    logic [10:0]     cls;
    logic            mret;
    logic            pred_nt;
    logic            illegal;
  } bundle_t;

  bundle_t dec_b;
  bundle_t out_q, out_d;
  bundle_t skid_q, skid_d;
  logic    dec_valid_q, dec_valid_d;
  logic    skid_valid_q, skid_valid_d;

  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic            can_load, accept;

  assign imm_i = XLEN'($signed(inst_code[31:20]));
  assign imm_s = XLEN'($signed({inst_code[31:25], inst_code[11:7]}));
  assign imm_b = XLEN'($signed({inst_code[31], inst_code[7], inst_code[30:25],
                                inst_code[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({inst_code[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({inst_code[31], inst_code[19:12], inst_code[20],
                                inst_code[30:21], 1'b0}));

  always_comb begin
    dec_b      = '0;
    dec_b.pc   = cur_inst_addr;
    dec_b.npc  = next_inst_addr;
    dec_b.inst = inst_code;
    dec_b.rd   = inst_code[11:7];
    dec_b.rs1  = inst_code[19:15];
    dec_b.rs2  = inst_code[24:20];
    dec_b.f3   = inst_code[14:12];
    dec_b.f7   = inst_code[31:25];
    dec_b.mret = (inst_code == XLEN'(32'h3020_0073));
    case (inst_code[6:0])
      OP_LUI:    begin dec_b.cls[C_LUI]    = 1'b1; dec_b.imm = imm_u; end
      OP_AUIPC:  begin dec_b.cls[C_AUIPC]  = 1'b1; dec_b.imm = imm_u; end
      OP_JAL:    begin dec_b.cls[C_JAL]    = 1'b1; dec_b.imm = imm_j; end
      OP_JALR:   begin dec_b.cls[C_JALR]   = 1'b1; dec_b.imm = imm_i; end
      OP_BRANCH: begin dec_b.cls[C_BRANCH] = 1'b1; dec_b.imm = imm_b; end
      OP_LOAD:   begin dec_b.cls[C_LOAD]   = 1'b1; dec_b.imm = imm_i; end
      OP_STORE:  begin dec_b.cls[C_STORE]  = 1'b1; dec_b.imm = imm_s; end
      OP_ALUI:   begin dec_b.cls[C_ALUI]   = 1'b1; dec_b.imm = imm_i; end
      OP_ALUR:   dec_b.cls[C_ALUR]   = 1'b1;
      OP_SYSTEM: dec_b.cls[C_SYSTEM] = 1'b1;
      OP_FENCE:  dec_b.cls[C_FENCE]  = 1'b1;
      default:   dec_b.illegal = 1'b1;
    endcase
    // Prediction flag only carries meaning for conditional branches.
    dec_b.pred_nt = control_hazard & dec_b.cls[C_BRANCH];
  end

  assign next_en  = !skid_valid_q;
  assign can_load = !dec_valid_q || ex_ready;
  assign accept   = inst_ready && next_en;

  always_comb begin
    out_d        = out_q;
    skid_d       = skid_q;
    dec_valid_d  = dec_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      dec_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (can_load && skid_valid_q) begin
      out_d        = skid_q;
      dec_valid_d  = 1'b1;
      skid_valid_d = 1'b0;
    end else if (can_load && accept) begin
      out_d       = dec_b;
      dec_valid_d = 1'b1;
    end else if (can_load) begin
      dec_valid_d = 1'b0;
    end else if (accept) begin
      skid_d       = dec_b;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q        <= '0;
      skid_q       <= '0;
      dec_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      dec_valid_q  <= dec_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign dec_valid   = dec_valid_q;
  assign dec_pc      = out_q.pc;
  assign dec_next_pc = out_q.npc;
  assign dec_inst    = out_q.inst;
  assign dec_rd      = out_q.rd;
  assign dec_rs1     = out_q.rs1;
  assign dec_rs2     = out_q.rs2;
  assign dec_funct3  = out_q.f3;
  assign dec_funct7  = out_q.f7;
  assign dec_imm     = out_q.imm;
  assign dec_class   = out_q.cls;
  assign dec_is_mret = out_q.mret;
  assign dec_pred_nt = out_q.pred_nt;
  assign dec_illegal = out_q.illegal;

endmodule

// File: tb/tb_inst_decode_stage.sv
// Self-checking bench for inst_decode_stage: directed decode vectors, stall/flush/reset
// scenarios and a randomized run against a queue-based model of the in-flight instructions.
module tb_inst_decode_stage;

  localparam int XLEN = 32;

  logic        clk = 1'b0;
  logic        rst, inst_ready, control_hazard, flush, ex_ready;
  logic [31:0] inst_code, cur_inst_addr, next_inst_addr;
  logic        next_en, dec_valid, dec_is_mret, dec_pred_nt, dec_illegal;
  logic [31:0] dec_pc, dec_next_pc, dec_inst, dec_imm;
  logic [4:0]  dec_rd, dec_rs1, dec_rs2;
  logic [2:0]  dec_funct3;
  logic [6:0]  dec_funct7;
  logic [10:0] dec_class;

  inst_decode_stage #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .inst_ready(inst_ready), .inst_code(inst_code),
    .cur_inst_addr(cur_inst_addr), .next_inst_addr(next_inst_addr),
    .control_hazard(control_hazard), .flush(flush), .ex_ready(ex_ready),
    .next_en(next_en), .dec_valid(dec_valid), .dec_pc(dec_pc),
    .dec_next_pc(dec_next_pc), .dec_inst(dec_inst), .dec_rd(dec_rd),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_funct3(dec_funct3),
    .dec_funct7(dec_funct7), .dec_imm(dec_imm), .dec_class(dec_class),
    .dec_is_mret(dec_is_mret), .dec_pred_nt(dec_pred_nt), .dec_illegal(dec_illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc, npc, inst;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [10:0] cls;
    logic        mret, pred_nt, illegal;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   fails  = 0;
  logic [6:0] ops [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                           7'h23, 7'h13, 7'h33, 7'h73, 7'h0F};

  function automatic int sext(input int v, input int bits);
    if (v >= (1 << (bits - 1))) return v - (1 << bits);
    return v;
  endfunction

  function automatic exp_t model_decode(input logic [31:0] w, input logic [31:0] pc,
                                        input logic [31:0] npc, input logic ch);
    exp_t e;
    int   k;
    int   v;
    e = '0;
    e.pc = pc; e.npc = npc; e.inst = w;
    e.rd = w[11:7]; e.rs1 = w[19:15]; e.rs2 = w[24:20];
    e.f3 = w[14:12]; e.f7 = w[31:25];
    e.mret = (w == 32'h3020_0073);
    k = -1;
    for (int i = 0; i < 11; i++) if (w[6:0] == ops[i]) k = i;
    v = 0;
    case (k)
      0, 1:       v = int'(w & 32'hFFFF_F000);
      2:          v = sext(int'(w[31]) * (1 << 20) + int'(w[19:12]) * (1 << 12)
                           + int'(w[20]) * (1 << 11) + int'(w[30:21]) * 2, 21);
      3, 5, 7:    v = sext(int'(w[31:20]), 12);
      4:          v = sext(int'(w[31]) * 4096 + int'(w[7]) * 2048
                           + int'(w[30:25]) * 32 + int'(w[11:8]) * 2, 13);
      6:          v = sext(int'(w[31:25]) * 32 + int'(w[11:7]), 12);
      default:    v = 0;
    endcase
    e.imm     = 32'(v);
    e.cls     = (k >= 0) ? 11'(1 << k) : 11'd0;
    e.illegal = (w[1:0] != 2'b11) || (k < 0);
    e.pred_nt = ch && (k == 4);
    return e;
  endfunction

  function automatic exp_t observed();
    exp_t o;
    o = '{dec_pc, dec_next_pc, dec_inst, dec_rd, dec_rs1, dec_rs2, dec_funct3,
          dec_funct7, dec_imm, dec_class, dec_is_mret, dec_pred_nt, dec_illegal};
    return o;
  endfunction

  task automatic drive(input logic ir, input logic [31:0] w, input logic [31:0] pc,
                       input logic ch, input logic er, input logic fl);
    inst_ready = ir; inst_code = w; cur_inst_addr = pc; next_inst_addr = pc + 32'd4;
    control_hazard = ch; ex_ready = er; flush = fl;
  endtask

  // Advance the model by one clock using the currently driven inputs, then the DUT.
  task automatic cycle();
    bit acc;
    acc = inst_ready && (q.size() < 2);
    if (flush) q.delete();
    else begin
      if (q.size() > 0 && ex_ready) void'(q.pop_front());
      if (acc) q.push_back(model_decode(inst_code, cur_inst_addr, next_inst_addr, control_hazard));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    #12;
    checks++; if (dec_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", dec_valid); end
    checks++; if (next_en !== 1'b1) begin fails++; $display("FAIL reset_next_en: got %b expected 1", next_en); end
    checks++; if (observed() !== exp_t'('0)) begin fails++; $display("FAIL reset_bundle: got %h expected 0", observed()); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    q.delete();
  endtask

  task automatic test_decode_vectors();
    logic [31:0] words [6] = '{32'h0051_0093, 32'hFE00_0EE3, 32'hFE00_0EE3,
                               32'h1234_52B7, 32'h3020_0073, 32'h0000_0000};
    logic        chs   [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] imms  [6] = '{32'd5, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h1234_5000, 32'd0, 32'd0};
    logic [10:0] clss  [6] = '{11'h080, 11'h010, 11'h010, 11'h001, 11'h200, 11'h000};
    logic        pnts  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, words[i], 32'(i * 4), chs[i], 1'b1, 1'b0);
      cycle();
      checks++; if (dec_valid !== 1'b1) begin fails++; $display("FAIL vec%0d_valid: got %b expected 1", i, dec_valid); end
      checks++; if (dec_imm !== imms[i]) begin fails++; $display("FAIL vec%0d_imm: got %h expected %h", i, dec_imm, imms[i]); end
      checks++; if (dec_class !== clss[i]) begin fails++; $display("FAIL vec%0d_class: got %h expected %h", i, dec_class, clss[i]); end
      checks++; if (dec_pred_nt !== pnts[i]) begin fails++; $display("FAIL vec%0d_pred_nt: got %b expected %b", i, dec_pred_nt, pnts[i]); end
      checks++; if (q.size() == 0 || observed() !== q[0]) begin fails++; $display("FAIL vec%0d_bundle: got %h expected %h", i, observed(), (q.size() > 0) ? q[0] : exp_t'('0)); end
    end
    checks++; if (dec_illegal !== 1'b1) begin fails++; $display("FAIL zero_illegal: got %b expected 1", dec_illegal); end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    cycle();
    checks++; if (dec_valid !== 1'b0) begin fails++; $display("FAIL drain_valid: got %b expected 0", dec_valid); end
  endtask

  task automatic test_stall();
    drive(1'b1, 32'h0051_0093, 32'h100, 1'b0, 1'b0, 1'b0); cycle();
    drive(1'b1, 32'h0020_8133, 32'h104, 1'b0, 1'b0, 1'b0); cycle();
    checks++; if (dec_inst !== 32'h0051_0093) begin fails++; $display("FAIL stall_hold: got %h expected 00510093", dec_inst); end
    checks++; if (next_en !== 1'b0) begin fails++; $display("FAIL stall_next_en: got %b expected 0", next_en); end
    drive(1'b1, 32'h0030_81B3, 32'h108, 1'b0, 1'b0, 1'b0); cycle();
    checks++; if (dec_inst !== 32'h0051_0093 || next_en !== 1'b0) begin fails++; $display("FAIL stall_blocked: got inst %h next_en %b expected 00510093 0", dec_inst, next_en); end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0); cycle();
    checks++; if (dec_valid !== 1'b1 || dec_inst !== 32'h0020_8133 || dec_pc !== 32'h104) begin fails++; $display("FAIL stall_release: got v%b %h pc %h expected v1 00208133 pc 104", dec_valid, dec_inst, dec_pc); end
    checks++; if (next_en !== 1'b1) begin fails++; $display("FAIL stall_release_next_en: got %b expected 1", next_en); end
    cycle();
    checks++; if (dec_valid !== 1'b0) begin fails++; $display("FAIL stall_no_dup: got %b expected 0", dec_valid); end
  endtask

  task automatic test_flush();
    drive(1'b1, 32'h0000_0013, 32'h200, 1'b0, 1'b0, 1'b0); cycle();
    drive(1'b1, 32'h0000_0093, 32'h204, 1'b0, 1'b0, 1'b0); cycle();
    drive(1'b1, 32'h0000_0113, 32'h208, 1'b0, 1'b0, 1'b1); cycle();
    checks++; if (dec_valid !== 1'b0 || next_en !== 1'b1) begin fails++; $display("FAIL flush_full: got v%b ne%b expected v0 ne1", dec_valid, next_en); end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0); cycle();
    checks++; if (dec_valid !== 1'b0) begin fails++; $display("FAIL flush_discard: got %b expected 0", dec_valid); end
    drive(1'b1, 32'h0000_0193, 32'h300, 1'b0, 1'b1, 1'b0); cycle();
    drive(1'b1, 32'h0000_0213, 32'h304, 1'b0, 1'b1, 1'b1); cycle();
    checks++; if (dec_valid !== 1'b0 || next_en !== 1'b1) begin fails++; $display("FAIL flush_accept: got v%b ne%b expected v0 ne1", dec_valid, next_en); end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid_stall();
    drive(1'b1, 32'h0000_0297, 32'h400, 1'b0, 1'b0, 1'b0); cycle();
    drive(1'b1, 32'h0000_006F, 32'h404, 1'b0, 1'b0, 1'b0); cycle();
    checks++; if (next_en !== 1'b0) begin fails++; $display("FAIL rst_prefill: got %b expected 0", next_en); end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    checks++; if (dec_valid !== 1'b0 || next_en !== 1'b1) begin fails++; $display("FAIL rst_async: got v%b ne%b expected v0 ne1", dec_valid, next_en); end
    q.delete();
    @(posedge clk); #1 rst = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0); cycle();
    checks++; if (dec_valid !== 1'b0) begin fails++; $display("FAIL rst_release: got %b expected 0", dec_valid); end
  endtask

  task automatic test_random();
    logic [31:0] w;
    logic [31:0] pc;
    pc = 32'h1000;
    for (int n = 0; n < 400; n++) begin
      w = $urandom;
      if ($urandom_range(0, 4) != 0) w[6:0] = ops[$urandom_range(0, 10)];
      if ($urandom_range(0, 15) == 0) w = 32'h3020_0073;
      drive(1'($urandom_range(0, 1)), w, pc, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0));
      if (inst_ready && q.size() < 2) pc = pc + 32'd4;
      cycle();
      checks++; if (dec_valid !== (q.size() > 0)) begin fails++; $display("FAIL rnd%0d_valid: got %b expected %b", n, dec_valid, q.size() > 0); end
      checks++; if (next_en !== (q.size() < 2)) begin fails++; $display("FAIL rnd%0d_next_en: got %b expected %b", n, next_en, q.size() < 2); end
      if (q.size() > 0) begin
        checks++; if (observed() !== q[0]) begin fails++; $display("FAIL rnd%0d_bundle: got %h expected %h", n, observed(), q[0]); end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_decode_vectors();
    test_stall();
    test_flush();
    test_reset_mid_stall();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
